// File: rtl/keyboard_spacebar.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deframes
// 11-bit scan-code frames and tracks make/break state of a single watched key.
module keyboard_spacebar #(
    parameter int          FILTER_LEN     = 8,
    parameter int          TIMEOUT_CYCLES = 65000,
    parameter logic [7:0]  SPACE_CODE     = 8'h29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       space_pressed,
    output logic       space_held,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data bits plus parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d, filt_prev_q;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_s;
    logic           timeout_s;
    state_t         state_q, state_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [16:0]    tcnt_q, tcnt_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           pressed_q, pressed_d;
    logic           held_q, held_d;
    logic           err_q, err_d;
    logic           brk_q, brk_d;
    logic           ext_q, ext_d;

    assign fall_s    = filt_prev_q & ~filt_q;
    assign timeout_s = (state_q != ST_IDLE) && !fall_s &&
                       (tcnt_q >= 17'(TIMEOUT_CYCLES - 1));

    // Glitch filter: the filtered clock follows only a level held for FILTER_LEN samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // Frame FSM, timeout watchdog and make/break decoder next-state logic.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tcnt_d      = tcnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        pressed_d   = 1'b0;
        held_d      = held_q;
        err_d       = 1'b0;
        brk_d       = brk_q;
        ext_d       = ext_q;

        if (state_q == ST_IDLE || fall_s) begin
            tcnt_d = 17'd0;
        end else begin
            tcnt_d = tcnt_q + 17'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s && !dat_s2_q) begin
                    state_d = ST_DATA;
                    bcnt_d  = 3'd0;
                    shift_d = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    state_d = (bcnt_q == 3'd7) ? ST_PARITY : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        key_code_d  = shift_q;
                        key_valid_d = 1'b1;
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            // Typematic repeats of a held key must not pulse again.
                            if (shift_q == SPACE_CODE && !ext_q) begin
                                if (brk_q) begin
                                    held_d = 1'b0;
                                end else if (!held_q) begin
                                    held_d    = 1'b1;
                                    pressed_d = 1'b1;
                                end else begin
                                    held_d = held_q;
                                end
                            end else begin
                                held_d = held_q;
                            end
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_s) begin
            state_d = ST_IDLE;
            tcnt_d  = 17'd0;
            err_d   = 1'b1;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
        end else begin
            tcnt_d = tcnt_d;
        end
    end

    // State and output registers; synchronizers reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            bcnt_q      <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tcnt_q      <= 17'd0;
            key_code_q  <= 8'h00;
            key_valid_q <= 1'b0;
            pressed_q   <= 1'b0;
            held_q      <= 1'b0;
            err_q       <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            pressed_q   <= pressed_d;
            held_q      <= held_d;
            err_q       <= err_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    assign key_code      = key_code_q;
    assign key_valid     = key_valid_q;
    assign space_pressed = pressed_q;
    assign space_held    = held_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_keyboard_spacebar.sv
// Scoreboard bench for keyboard_spacebar: a key-event model queues expected
// responses per frame, a monitor compares each DUT output event.
module tb_keyboard_spacebar;

    localparam int HALF = 25;
    localparam int TMO  = 800;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid, space_pressed, space_held, frame_err;

    keyboard_spacebar #(
        .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .SPACE_CODE(8'h29)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .key_valid(key_valid),
        .space_pressed(space_pressed), .space_held(space_held),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       pressed;
        logic       held;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  m_held = 1'b0, m_brk = 1'b0, m_ext = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a key event described by keyboard semantics (press/release/prefix).
    task automatic model_frame(input logic [7:0] b, input bit bad);
        ev_t e;
        e = '0;
        if (bad) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
            e.err = 1'b1;
        end else begin
            e.code = b;
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else begin
                if (b == 8'h29 && !m_ext) begin
                    if (m_brk) m_held = 1'b0;
                    else if (!m_held) begin
                        m_held = 1'b1;
                        e.pressed = 1'b1;
                    end
                end
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
        e.held = m_held;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        model_frame(b, bad);
        send_bits(b, bad, 11);
    endtask

    task automatic send_partial(input int nbits);
        model_frame(8'h00, 1'b1);
        send_bits(8'h29, 1'b0, nbits);
        repeat (TMO + 100) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, key_code, 8'h00);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_pressed"}, space_pressed, 1'b0);
        check({tag, "_held"}, space_held, 1'b0);
        check({tag, "_err"}, frame_err, 1'b0);
    endtask

    // Monitor: every DUT output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst && (key_valid || frame_err || space_pressed)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {key_valid, frame_err, space_pressed}, 3'b000);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("frame_err", frame_err, e.err);
                check("key_valid", key_valid, !e.err);
                check("space_pressed", space_pressed, e.pressed);
                check("space_held", space_held, e.held);
                if (!e.err) check("key_code", key_code, e.code);
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        repeat (20) @(negedge clk);

        send_frame(8'h29, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(8'h29, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h29, 1'b1);
        send_frame(8'h29, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        send_partial(5);
        send_frame(8'h29, 1'b0);

        // A short low glitch with data low would start a frame if it leaked through.
        @(negedge clk) ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_code", key_code, 8'h29);
        check("glitch_held", space_held, 1'b1);
        send_frame(8'h1C, 1'b0);

        send_frame(8'h29, 1'b0);
        send_bits(8'h29, 1'b0, 4);
        @(negedge clk) rst = 1'b0;
        #1 check_all_zero("midreset");
        m_held = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h29, 1'b0);

        for (int n = 0; n < 55; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: send_frame(8'h29, 1'b0);
                3:       send_frame(8'hF0, 1'b0);
                4:       send_frame(8'hE0, 1'b0);
                5:       send_frame(8'h1C, 1'b0);
                7:       send_frame(8'($urandom_range(0, 255)), 1'b1);
                8:       send_partial(int'($urandom_range(1, 10)));
                default: send_frame(8'($urandom_range(0, 255)), 1'b0);
            endcase
        end

        repeat (100) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
